// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), total-length helper and RGB field widths.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int RGB_R_W = 4;
    localparam int RGB_G_W = 4;
    localparam int RGB_B_W = 4;
    localparam int RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA axis (horizontal or vertical): position counter with blank/sync decoded from the
// next count so they stay aligned with the registered count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int CNT_W  = 11
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             blank,
    output logic             sync,
    output logic             wrap
);

    localparam int               TOTAL      = vga_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [31:0]      ACT_L      = 32'(ACTIVE);
    localparam logic [31:0]      SYNC_START = 32'(ACTIVE + FP);
    localparam logic [31:0]      SYNC_END   = 32'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] count_next;
    logic [31:0]      count_next_w;

    always_comb begin
        wrap       = step && (count == LAST);
        count_next = count;
        if (wrap) begin
            count_next = '0;
        end else if (step) begin
            count_next = count + CNT_W'(1);
        end
        // Widened copy so sync/blank bounds may equal TOTAL without overflowing CNT_W.
        count_next_w = 32'(count_next);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count <= '0;
            blank <= 1'b0;
            sync  <= ~POL;
        end else begin
            count <= count_next;
            blank <= (count_next_w >= ACT_L);
            sync  <= ((count_next_w >= SYNC_START) && (count_next_w < SYNC_END)) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel/line/frame/update strobes.
// Optional colour-bar output PatternRGB when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COORD_W  = 11
) (
    input  logic               CLK_100MHz,
    input  logic               Reset,
    input  logic [7:0]         FrameDiv,
    output logic               HS,
    output logic               VS,
    output logic               HBlank,
    output logic               VBlank,
    output logic [COORD_W-1:0] CurrentX,
    output logic [COORD_W-1:0] CurrentY,
    output logic               PixelTick,
    output logic               LineTick,
    output logic               FrameTick,
    output logic               UpdateTick
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [RGB_W-1:0]   PatternRGB
`endif
);

    localparam int H_TOTAL   = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL   = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] Y_PRE_BLANK = COORD_W'(V_ACTIVE - 1);

    generate
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $error("vga_timing_gen: CLK_DIV must be >= 1");
        end
        if (longint'(MAX_TOTAL - 1) >= (longint'(1) << COORD_W)) begin : g_bad_coord_w
            $error("vga_timing_gen: COORD_W too narrow for max(H_TOTAL, V_TOTAL) - 1");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt_reg;
    logic             pixel_step;
    logic             h_wrap;
    logic             v_wrap;
    logic             frame_step;
    logic [7:0]       frame_cnt_reg;
    logic [7:0]       div_lat_reg;
    logic [7:0]       frame_div_eff;

    assign pixel_step    = (div_cnt_reg == DIV_LAST);
    assign frame_step    = h_wrap && (CurrentY == Y_PRE_BLANK);
    assign frame_div_eff = (FrameDiv == 8'd0) ? 8'd1 : FrameDiv;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .CNT_W  (COORD_W)
    ) u_h_axis (
        .clk   (CLK_100MHz),
        .srst  (Reset),
        .step  (pixel_step),
        .count (CurrentX),
        .blank (HBlank),
        .sync  (HS),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .CNT_W  (COORD_W)
    ) u_v_axis (
        .clk   (CLK_100MHz),
        .srst  (Reset),
        .step  (h_wrap),
        .count (CurrentY),
        .blank (VBlank),
        .sync  (VS),
        .wrap  (v_wrap)
    );

    // Strobes are registered on the same edge the counters advance, so each pulse
    // shares its cycle with the coordinates it describes.
    always_ff @(posedge CLK_100MHz) begin
        if (Reset) begin
            div_cnt_reg   <= '0;
            frame_cnt_reg <= 8'd0;
            div_lat_reg   <= frame_div_eff;
            PixelTick     <= 1'b0;
            LineTick      <= 1'b0;
            FrameTick     <= 1'b0;
            UpdateTick    <= 1'b0;
        end else begin
            div_cnt_reg <= pixel_step ? '0 : div_cnt_reg + DIV_W'(1);
            PixelTick   <= pixel_step;
            LineTick    <= h_wrap;
            FrameTick   <= frame_step;
            UpdateTick  <= 1'b0;
            if (frame_step) begin
                if (frame_cnt_reg == div_lat_reg - 8'd1) begin
                    UpdateTick    <= 1'b1;
                    frame_cnt_reg <= 8'd0;
                    div_lat_reg   <= frame_div_eff;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 8'd1;
                end
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    logic [2:0]         bar_idx;
    logic [RGB_W-1:0]   pattern_next;

    always_comb begin
        x_next = CurrentX;
        y_next = CurrentY;
        if (h_wrap) begin
            x_next = '0;
            y_next = v_wrap ? '0 : CurrentY + COORD_W'(1);
        end else if (pixel_step) begin
            x_next = CurrentX + COORD_W'(1);
        end
        bar_idx      = 3'(int'(x_next) / BAR_W);
        pattern_next = '0;
        if ((int'(x_next) < H_ACTIVE) && (int'(y_next) < V_ACTIVE)) begin
            pattern_next = {{RGB_R_W{bar_idx[2]}}, {RGB_G_W{bar_idx[1]}}, {RGB_B_W{bar_idx[0]}}};
        end
    end

    always_ff @(posedge CLK_100MHz) begin
        if (Reset) begin
            PatternRGB <= '0;
        end else begin
            PatternRGB <= pattern_next;
        end
    end
`else
    // The vertical wrap only feeds the colour-bar logic.
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small-geometry instances checked cycle by cycle against a
// pixel-count arithmetic model, with randomized FrameDiv changes and reset pulses.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] fd;

    always #5 clk = ~clk;

    // Instance 0: CLK_DIV=2, active-low syncs. Instance 1: CLK_DIV=1, active-high syncs.
    logic       d0_hs, d0_vs, d0_hb, d0_vb, d0_pt, d0_lt, d0_ft, d0_upd;
    logic [3:0] d0_x, d0_y;
    logic       d1_hs, d1_vs, d1_hb, d1_vb, d1_pt, d1_lt, d1_ft, d1_upd;
    logic [3:0] d1_x, d1_y;
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] d0_rgb, d1_rgb, dw_rgb;
    logic        dw_hs, dw_vs, dw_hb, dw_vb, dw_pt, dw_lt, dw_ft, dw_upd;
    logic [10:0] dw_x, dw_y;
`endif

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .COORD_W(4)
    ) dut (
        .CLK_100MHz(clk), .Reset(rst), .FrameDiv(fd),
        .HS(d0_hs), .VS(d0_vs), .HBlank(d0_hb), .VBlank(d0_vb),
        .CurrentX(d0_x), .CurrentY(d0_y),
        .PixelTick(d0_pt), .LineTick(d0_lt), .FrameTick(d0_ft), .UpdateTick(d0_upd)
`ifdef VGA_TEST_PATTERN_EN
        , .PatternRGB(d0_rgb)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .COORD_W(4)
    ) dut_pol (
        .CLK_100MHz(clk), .Reset(rst), .FrameDiv(fd),
        .HS(d1_hs), .VS(d1_vs), .HBlank(d1_hb), .VBlank(d1_vb),
        .CurrentX(d1_x), .CurrentY(d1_y),
        .PixelTick(d1_pt), .LineTick(d1_lt), .FrameTick(d1_ft), .UpdateTick(d1_upd)
`ifdef VGA_TEST_PATTERN_EN
        , .PatternRGB(d1_rgb)
`endif
    );

`ifdef VGA_TEST_PATTERN_EN
    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .COORD_W(11)
    ) dut_wide (
        .CLK_100MHz(clk), .Reset(rst), .FrameDiv(fd),
        .HS(dw_hs), .VS(dw_vs), .HBlank(dw_hb), .VBlank(dw_vb),
        .CurrentX(dw_x), .CurrentY(dw_y),
        .PixelTick(dw_pt), .LineTick(dw_lt), .FrameTick(dw_ft), .UpdateTick(dw_upd),
        .PatternRGB(dw_rgb)
    );
`endif

    typedef struct {
        int x;
        int y;
        bit hs, vs, hb, vb, pt, lt, ft;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   k     = 0;        // clock edges since reset was last released
    exp_t e [2];
    bit   upd_exp [2];
    int   fcnt [2];
    int   dlat [2];

    // Position follows from how many pixel periods have elapsed since reset release.
    function automatic exp_t model(int kk, int d, int ha, int hf, int hsw, int hbp,
                                   int va, int vf, int vsw, int vbp, bit hpol, bit vpol);
        exp_t m;
        int   ht, vt, p;
        ht   = ha + hf + hsw + hbp;
        vt   = va + vf + vsw + vbp;
        p    = kk / d;
        m.x  = p % ht;
        m.y  = (p / ht) % vt;
        m.pt = (kk > 0) && (kk % d == 0);
        m.lt = m.pt && (m.x == 0);
        m.ft = m.lt && (m.y == va);
        m.hb = (m.x >= ha);
        m.vb = (m.y >= va);
        m.hs = (m.x >= ha + hf && m.x < ha + hf + hsw) ? hpol : !hpol;
        m.vs = (m.y >= va + vf && m.y < va + vf + vsw) ? vpol : !vpol;
        return m;
    endfunction

    function automatic exp_t exp_for(int i, int kk);
        if (i == 0) return model(kk, 2, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0);
        return model(kk, 1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1);
    endfunction

    function automatic logic [22:0] pack_exp(exp_t m);
        return {8'(m.x), 8'(m.y), m.hs, m.vs, m.hb, m.vb, m.pt, m.lt, m.ft};
    endfunction

    function automatic logic [22:0] pack_obs(int i);
        if (i == 0) return {8'(d0_x), 8'(d0_y), d0_hs, d0_vs, d0_hb, d0_vb, d0_pt, d0_lt, d0_ft};
        return {8'(d1_x), 8'(d1_y), d1_hs, d1_vs, d1_hb, d1_vb, d1_pt, d1_lt, d1_ft};
    endfunction

    function automatic int eff_div(logic [7:0] v);
        return (v == 8'd0) ? 1 : int'(v);
    endfunction

    // Advance one clock and the reference model; leaves the bench at the following negedge.
    task automatic clock_cycle();
        logic r;
        r = rst;
        @(posedge clk);
        k = r ? 0 : k + 1;
        for (int i = 0; i < 2; i++) begin
            e[i]       = exp_for(i, k);
            upd_exp[i] = 1'b0;
            if (r) begin
                fcnt[i] = 0;
                dlat[i] = eff_div(fd);
            end else if (e[i].ft) begin
                if (fcnt[i] + 1 == dlat[i]) begin
                    upd_exp[i] = 1'b1;
                    fcnt[i]    = 0;
                    dlat[i]    = eff_div(fd);
                end else begin
                    fcnt[i] = fcnt[i] + 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [22:0] rst0, rst1;
        rst0 = {8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000};
        rst1 = {8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        rst = 1'b1;
        fd  = 8'd3;
        repeat (3) clock_cycle();
        n_vec++;
        if (pack_obs(0) !== rst0) begin
            n_err++;
            $display("FAIL reset_state0 got=%h exp=%h", pack_obs(0), rst0);
        end
        n_vec++;
        if (pack_obs(1) !== rst1) begin
            n_err++;
            $display("FAIL reset_state1 got=%h exp=%h", pack_obs(1), rst1);
        end
        n_vec++;
        if ({d0_upd, d1_upd} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_update got=%b exp=00", {d0_upd, d1_upd});
        end
        $display("test_reset: done after 3 reset cycles");
    endtask

    task automatic test_timing();
        int n_lt, n_ft, first_pt;
        n_lt = 0; n_ft = 0; first_pt = -1;
        rst = 1'b0;
        for (int c = 1; c <= 392; c++) begin
            clock_cycle();
            n_vec++;
            if (pack_obs(0) !== pack_exp(e[0])) begin
                n_err++;
                $display("FAIL timing k=%0d got=%h exp=%h", k, pack_obs(0), pack_exp(e[0]));
            end
            if (d0_lt) n_lt++;
            if (d0_ft) n_ft++;
            if (d0_pt && first_pt < 0) first_pt = c;
        end
        n_vec++;
        if (first_pt !== 2) begin
            n_err++;
            $display("FAIL first_pixel_tick got=%0d exp=2", first_pt);
        end
        n_vec++;
        if (n_lt !== 14) begin
            n_err++;
            $display("FAIL line_tick_count got=%0d exp=14", n_lt);
        end
        n_vec++;
        if (n_ft !== 2) begin
            n_err++;
            $display("FAIL frame_tick_count got=%0d exp=2", n_ft);
        end
        $display("test_timing: 2 frames, %0d line ticks, %0d frame ticks", n_lt, n_ft);
    endtask

    task automatic test_polarity();
        int n_pt;
        n_pt = 0;
        for (int c = 0; c < 200; c++) begin
            clock_cycle();
            n_vec++;
            if (pack_obs(1) !== pack_exp(e[1])) begin
                n_err++;
                $display("FAIL polarity k=%0d got=%h exp=%h", k, pack_obs(1), pack_exp(e[1]));
            end
            if (d1_pt) n_pt++;
        end
        n_vec++;
        if (n_pt !== 200) begin
            n_err++;
            $display("FAIL div1_pixel_tick_count got=%0d exp=200", n_pt);
        end
        $display("test_polarity: %0d pixel ticks in 200 cycles", n_pt);
    endtask

    task automatic test_update();
        int         ft_seen, cyc;
        logic [7:0] mask;
        ft_seen = 0; cyc = 0; mask = 8'h00;
        fd  = 8'd3;
        rst = 1'b1;
        repeat (2) clock_cycle();
        rst = 1'b0;
        while (ft_seen < 8 && cyc < 3000) begin
            clock_cycle();
            cyc++;
            n_vec++;
            if (d0_upd !== upd_exp[0]) begin
                n_err++;
                $display("FAIL update_tick k=%0d got=%b exp=%b", k, d0_upd, upd_exp[0]);
            end
            if (e[0].ft) begin
                if (d0_upd) mask[ft_seen] = 1'b1;
                ft_seen++;
                if (ft_seen == 4) fd = 8'd0;
            end
        end
        n_vec++;
        if (ft_seen !== 8) begin
            n_err++;
            $display("FAIL update_timeout got=%0d frames exp=8", ft_seen);
        end
        n_vec++;
        if (mask !== 8'b1110_0100) begin
            n_err++;
            $display("FAIL update_pattern got=%b exp=11100100", mask);
        end
        $display("test_update: update mask over 8 frames = %b", mask);
    endtask

    task automatic test_midframe_reset();
        int          cyc, first_pt;
        logic [22:0] rst0;
        rst0 = {8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000};
        cyc = 0;
        first_pt = -1;
        while (!(e[0].x == 5 && e[0].y == 2) && cyc < 500) begin
            clock_cycle();
            cyc++;
        end
        n_vec++;
        if ({d0_x, d0_y} !== {4'd5, 4'd2}) begin
            n_err++;
            $display("FAIL reach_5_2 got=(%0d,%0d) exp=(5,2)", d0_x, d0_y);
        end
        rst = 1'b1;
        clock_cycle();
        n_vec++;
        if ({pack_obs(0), d0_upd} !== {rst0, 1'b0}) begin
            n_err++;
            $display("FAIL midframe_reset got=%h exp=%h", {pack_obs(0), d0_upd}, {rst0, 1'b0});
        end
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            clock_cycle();
            if (d0_pt) begin
                first_pt = c;
                break;
            end
        end
        n_vec++;
        if (first_pt !== 2) begin
            n_err++;
            $display("FAIL post_reset_pixel_tick got=%0d exp=2", first_pt);
        end
        $display("test_midframe_reset: first pixel tick %0d cycles after release", first_pt);
    endtask

    task automatic test_random();
        int n, nr;
        for (int it = 0; it < 25; it++) begin
            fd = 8'($urandom_range(0, 5));
            n  = $urandom_range(20, 300);
            nr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            for (int c = 0; c < nr + n; c++) begin
                rst = (c < nr);
                clock_cycle();
                for (int i = 0; i < 2; i++) begin
                    n_vec++;
                    if (pack_obs(i) !== pack_exp(e[i])) begin
                        n_err++;
                        $display("FAIL random_timing%0d k=%0d got=%h exp=%h", i, k, pack_obs(i), pack_exp(e[i]));
                    end
                end
                n_vec++;
                if ({d0_upd, d1_upd} !== {upd_exp[0], upd_exp[1]}) begin
                    n_err++;
                    $display("FAIL random_update k=%0d got=%b%b exp=%b%b", k, d0_upd, d1_upd, upd_exp[0], upd_exp[1]);
                end
            end
            rst = 1'b0;
            $display("test_random: iter %0d FrameDiv=%0d reset_cycles=%0d run=%0d", it, fd, nr, n);
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    function automatic logic [11:0] rgb_model(int x, int y);
        logic [2:0] bi;
        if (x < 640 && y < 4) begin
            bi = 3'(x / 80);
            return {{4{bi[2]}}, {4{bi[1]}}, {4{bi[0]}}};
        end
        return 12'h000;
    endfunction

    task automatic test_pattern();
        exp_t        m;
        logic [11:0] want;
        rst = 1'b1;
        clock_cycle();
        rst = 1'b0;
        for (int c = 0; c < 1700; c++) begin
            clock_cycle();
            m    = model(k, 1, 640, 16, 96, 48, 4, 1, 1, 1, 1'b0, 1'b0);
            want = rgb_model(m.x, m.y);
            n_vec++;
            if ({dw_x, dw_rgb} !== {11'(m.x), want}) begin
                n_err++;
                $display("FAIL pattern k=%0d got x=%0d rgb=%h exp x=%0d rgb=%h", k, dw_x, dw_rgb, m.x, want);
            end
        end
        $display("test_pattern: 1700 cycles of colour bars");
    endtask
`endif

    initial begin
        rst = 1'b1;
        fd  = 8'd3;
        test_reset();
        test_timing();
        test_polarity();
        test_update();
        test_midframe_reset();
        test_random();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator; next generation of the fixed 640x480 driver used by the snake game top level.
- Generalises resolution, porch/sync widths, sync polarity and pixel-clock division.
- Adds line, frame and game-update strobes, so the game logic no longer needs its own update-clock divider.
- Sits between the system clock and the pixel client (game renderer); drives the VGA connector sync pins.

Parameters:
- CLK_DIV, 4: system clocks per pixel (4 gives 25 MHz from 100 MHz); must be >= 1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: asserted level of HS (0 means active-low).
- VS_POL, 0: asserted level of VS (0 means active-low).
- COORD_W, 11: width of the coordinate outputs.

Ports:
- CLK_100MHz  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- FrameDiv  in  8  frames per UpdateTick; 0 is treated as 1.
- HS  out  1  horizontal sync.
- VS  out  1  vertical sync.
- HBlank  out  1  high outside the horizontal active region.
- VBlank  out  1  high outside the vertical active region.
- CurrentX  out  COORD_W  horizontal pixel count, 0..H_TOTAL-1.
- CurrentY  out  COORD_W  vertical line count, 0..V_TOTAL-1.
- PixelTick  out  1  one-cycle pulse per pixel period.
- LineTick  out  1  one-cycle pulse at the start of each line.
- FrameTick  out  1  one-cycle pulse on entry to vertical blank.
- UpdateTick  out  1  one-cycle pulse every FrameDiv frames.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL is defined the same way from the V_ parameters.
- Pixel divider:
  - Counter runs 0..CLK_DIV-1 and wraps.
  - PixelTick is high in the cycle the counter equals CLK_DIV-1.
  - If CLK_DIV = 1, PixelTick is constantly high after reset.
- Horizontal counter: on PixelTick, CurrentX increments; it wraps from H_TOTAL-1 to 0.
- Vertical counter: on the same tick as the X wrap, CurrentY increments; it wraps from V_TOTAL-1 to 0.
- Output alignment:
  - All outputs are registered.
  - HS, VS, HBlank and VBlank are decoded from the next-state counter values, so they change in the same cycle as CurrentX/CurrentY. There is zero relative latency.
- Decodes:
  - HBlank = (X >= H_ACTIVE).
  - HS = HS_POL when H_ACTIVE+H_FP <= X < H_ACTIVE+H_FP+H_SYNC; otherwise ~HS_POL.
  - VBlank and VS follow the same rules using Y and the V_ parameters.
- LineTick: high for one cycle, in the cycle X becomes 0.
- FrameTick: high for one cycle, in the cycle (X, Y) becomes (0, V_ACTIVE).
- Frame counter and UpdateTick:
  - Counts FrameTicks. UpdateTick pulses with the FrameTick that brings the count to the latched divisor; the count then clears.
  - FrameDiv is latched at reset release and again at each UpdateTick. Mid-period changes take effect at the next period.
- Reset:
  - All counters are 0.
  - CurrentX = 0 and CurrentY = 0.
  - HBlank = 0 and VBlank = 0.
  - HS = ~HS_POL and VS = ~VS_POL.
  - All ticks are 0.
  - Latched divisor is max(FrameDiv, 1).
- Mid-frame Reset: everything returns to reset values on the next edge. The first post-reset PixelTick occurs CLK_DIV cycles after Reset deasserts.
- Elaboration error: raised if COORD_W cannot hold max(H_TOTAL, V_TOTAL) - 1.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Adds output PatternRGB[11:0] (R[11:8], G[7:4], B[3:0]), registered and aligned with CurrentX.
  - In the active region it shows 8 vertical colour bars, each H_ACTIVE/8 wide. Bar index i drives R = {4{i[2]}}, G = {4{i[1]}}, B = {4{i[0]}}.
  - In blank it is 12'h000.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package vga_pkg holds:
  - default timing constants (640x480@60);
  - derived H_TOTAL/V_TOTAL function;
  - RGB field widths (4/4/4).
- One sub-module, vga_axis_counter, instanced twice (H and V). Parameters: ACTIVE, FP, SYNC, BP, POL. Inputs: step enable. Outputs: count, blank, sync and wrap.

Test Plan:
- Small config (CLK_DIV=2; H 8/2/2/2; V 4/1/1/1), Reset for 3 cycles then release -> PixelTick every 2nd cycle; X wraps 13 -> 0; HS low exactly for X = 10..11; HBlank high for X = 8..13.
- Same config run for 2 frames -> FrameTick at (0,4) once per 98 pixel periods; VS low only on Y = 5; LineTick 7 per frame.
- Default config with FrameDiv = 3 -> UpdateTick on every 3rd FrameTick. Switch FrameDiv to 0 mid-period -> the current period still completes at 3, then UpdateTick occurs every frame.
- Assert Reset at (X = 5, Y = 2) -> next cycle X = 0, Y = 0, HS = 1, VS = 1, all ticks 0. The first PixelTick follows CLK_DIV cycles after release.
- HS_POL = 1 and VS_POL = 1 -> sync pulses are inverted; blank and tick timing are unchanged.
- With VGA_TEST_PATTERN_EN at 640 width: X = 0 -> 12'h000; X = 80 -> 12'h00F; X = 639 -> 12'hFFF; in blank -> 12'h000.
